// File: rtl/rx_bps_gen_pkg.sv
// Shared definitions for the UART receive bit-timing generator.
// Holds the state encoding, the standard 50 MHz baud divisors and the divisor clamp helper.
package rx_bps_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int unsigned DIV_9600_50M    = 5208;
   localparam int unsigned DIV_115200_50M  = 434;
   localparam int unsigned OS_LOG2_DEFAULT = 4;

   // A divisor below 2*OS would leave less than two clocks per oversample tick.
   function automatic int unsigned clamp_div(input int unsigned val, input int unsigned min_val);
      return (val < min_val) ? min_val : val;
   endfunction

endpackage

// File: rtl/rx_bps_gen_os_tick_gen.sv
// Oversample tick generator: emits exactly 1<<OS_LOG2 evenly spaced ticks per bit,
// restarting its phase at every bit wrap.
module os_tick_gen
   import rx_bps_gen_pkg::*;
#(
   parameter int DIV_W   = 16,
   parameter int OS_LOG2 = OS_LOG2_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] os_div,
   input  logic             run,
   input  logic             bit_wrap,
   output logic             os_tick
);

   localparam int OS = 1 << OS_LOG2;

   logic [DIV_W-1:0]   os_cnt;
   logic [OS_LOG2:0]   tick_cnt;
   logic               ticks_left;
   logic               at_tick;

   assign ticks_left = (tick_cnt != (OS_LOG2 + 1)'(OS));
   assign at_tick    = run && ticks_left && (os_cnt == os_div - DIV_W'(1));
   assign os_tick    = at_tick;

   // Once OS ticks have been issued the sub-counter parks until the bit wraps.
   always_ff @(posedge clk) begin
      if (!rst_n || !run || bit_wrap) begin
         os_cnt   <= '0;
         tick_cnt <= '0;
      end else if (ticks_left) begin
         if (at_tick) begin
            os_cnt   <= '0;
            tick_cnt <= tick_cnt + (OS_LOG2 + 1)'(1);
         end else begin
            os_cnt <= os_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/rx_bps_gen.sv
// Bit-timing generator for the UART receive path: loadable divisor, mid-bit sample strobe,
// oversample ticks, bit-end strobe, bit index and frame-done.
module rx_bps_gen
   import rx_bps_gen_pkg::*;
#(
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = DIV_115200_50M,
   parameter int OS_LOG2     = OS_LOG2_DEFAULT,
   parameter int FRAME_BITS  = 10,
   localparam int IDX_W      = $clog2(FRAME_BITS)
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             Count_Sig,
   input  logic             Div_Load,
   input  logic [DIV_W-1:0] Div_Val,
   output logic             Load_Ack,
   output logic             Load_Err,
   output logic             Busy,
   output logic             Os_Tick,
   output logic             Sample_Pulse,
   output logic             Bit_End,
   output logic [IDX_W-1:0] Bit_Idx,
   output logic             Frame_Done
);

   localparam int unsigned MIN_DIV = 2 * (1 << OS_LOG2);

   state_t           state;
   state_t           next_state;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] os_div;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_clamped;
   logic             in_run;
   logic             bit_wrap;
   logic             last_bit;

   assign in_run      = (state == RUN);
   assign bit_wrap    = in_run && (cnt == div_q - DIV_W'(1));
   assign last_bit    = (Bit_Idx == IDX_W'(FRAME_BITS - 1));
   assign div_clamped = DIV_W'(clamp_div(32'(Div_Val), MIN_DIV));

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (Count_Sig) next_state = RUN;
         RUN: begin
            if (!Count_Sig)              next_state = IDLE;
            else if (bit_wrap && last_bit) next_state = HOLD;
         end
         HOLD:    if (!Count_Sig) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Any move to IDLE (abort or normal release) clears the counters; HOLD keeps the last index.
   always_ff @(posedge CLK) begin
      if (!RST_n || next_state == IDLE) begin
         cnt     <= '0;
         Bit_Idx <= '0;
      end else if (in_run) begin
         if (bit_wrap) begin
            cnt <= '0;
            if (!last_bit) Bit_Idx <= Bit_Idx + IDX_W'(1);
         end else begin
            cnt <= cnt + DIV_W'(1);
         end
      end
   end

   // Loads are only honoured while idle so a running frame never changes period mid-bit.
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         div_q    <= DIV_W'(DEFAULT_DIV);
         os_div   <= DIV_W'(DEFAULT_DIV >> OS_LOG2);
         Load_Ack <= 1'b0;
         Load_Err <= 1'b0;
      end else begin
         Load_Ack <= Div_Load && (state == IDLE);
         Load_Err <= Div_Load && (state != IDLE);
         if (Div_Load && state == IDLE) begin
            div_q  <= div_clamped;
            os_div <= div_clamped >> OS_LOG2;
         end
      end
   end

   os_tick_gen #(
      .DIV_W   (DIV_W),
      .OS_LOG2 (OS_LOG2)
   ) u_os_tick_gen (
      .clk      (CLK),
      .rst_n    (RST_n),
      .os_div   (os_div),
      .run      (in_run),
      .bit_wrap (bit_wrap),
      .os_tick  (Os_Tick)
   );

   assign Busy         = (state != IDLE);
   assign Sample_Pulse = in_run && (cnt == (div_q >> 1));
   assign Bit_End      = bit_wrap;
   assign Frame_Done   = bit_wrap && last_bit;

endmodule

// File: tb/tb_rx_bps_gen.sv
// Directed self-checking bench for rx_bps_gen: frame timing, oversample ticks,
// divisor load/clamp/reject, abort and mid-frame reset.
module tb_rx_bps_gen;

   localparam int DIV_W      = 16;
   localparam int FRAME_BITS = 10;
   localparam int IDX_W      = $clog2(FRAME_BITS);
   localparam int OS         = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             count_sig;
   logic             div_load;
   logic [DIV_W-1:0] div_val;
   logic             load_ack;
   logic             load_err;
   logic             busy;
   logic             os_tick;
   logic             sample_pulse;
   logic             bit_end;
   logic [IDX_W-1:0] bit_idx;
   logic             frame_done;

   int checks = 0;
   int errors = 0;

   int n_sample, n_end, n_done, n_tick, n_bad, done_at;

   rx_bps_gen dut (
      .CLK          (clk),
      .RST_n        (rst_n),
      .Count_Sig    (count_sig),
      .Div_Load     (div_load),
      .Div_Val      (div_val),
      .Load_Ack     (load_ack),
      .Load_Err     (load_err),
      .Busy         (busy),
      .Os_Tick      (os_tick),
      .Sample_Pulse (sample_pulse),
      .Bit_End      (bit_end),
      .Bit_Idx      (bit_idx),
      .Frame_Done   (frame_done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Advance one rising edge and settle just past it.
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clearStats();
      n_sample = 0; n_end = 0; n_done = 0; n_tick = 0; n_bad = 0; done_at = -1;
   endtask

   // Cycle k of a running frame (k counted from the edge that entered RUN); compare every strobe
   // against an independent model of where it belongs, then advance.
   task automatic applyStimulus(input int div, input int kstart, input int kend);
      int c, odiv;
      bit e_sample, e_end, e_done, e_tick;
      odiv = div / OS;
      for (int k = kstart; k < kend; k++) begin
         c        = k % div;
         e_sample = (c == div / 2);
         e_end    = (c == div - 1);
         e_done   = e_end && (k / div == FRAME_BITS - 1);
         e_tick   = ((c % odiv) == odiv - 1) && (c < OS * odiv);
         if (sample_pulse != e_sample || bit_end != e_end || frame_done != e_done ||
             os_tick != e_tick || int'(bit_idx) != k / div || busy != 1'b1)
            n_bad++;
         n_sample += int'(sample_pulse);
         n_end    += int'(bit_end);
         n_tick   += int'(os_tick);
         if (frame_done) begin
            n_done++;
            done_at = k;
         end
         stepCycle();
      end
   endtask

   task automatic loadDiv(input int val, input int exp_ack);
      div_load = 1'b1;
      div_val  = DIV_W'(val);
      stepCycle();
      div_load = 1'b0;
      checkOutput("load_ack", int'(load_ack), exp_ack);
      stepCycle();
      checkOutput("load_ack_pulse", int'(load_ack), 0);
   endtask

   initial begin
      rst_n = 1'b0; count_sig = 1'b0; div_load = 1'b0; div_val = '0;
      repeat (3) stepCycle();
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_idx", int'(bit_idx), 0);
      checkOutput("rst_strobes", int'({sample_pulse, bit_end, frame_done, os_tick, load_ack, load_err}), 0);
      rst_n = 1'b1;
      stepCycle();

      // Default 434-clock frame, then HOLD until Count_Sig drops.
      clearStats();
      count_sig = 1'b1;
      stepCycle();
      applyStimulus(434, 0, 4340);
      checkOutput("def_sample_n", n_sample, 10);
      checkOutput("def_end_n", n_end, 10);
      checkOutput("def_done_n", n_done, 1);
      checkOutput("def_done_at", done_at, 4339);
      checkOutput("def_tick_n", n_tick, 160);
      checkOutput("def_bad", n_bad, 0);
      checkOutput("hold_busy", int'(busy), 1);
      checkOutput("hold_idx", int'(bit_idx), 9);
      checkOutput("hold_strobes", int'({sample_pulse, bit_end, frame_done, os_tick}), 0);
      count_sig = 1'b0;
      stepCycle();
      checkOutput("release_busy", int'(busy), 0);
      checkOutput("release_idx", int'(bit_idx), 0);

      // 9600 baud divisor: two bits then abort.
      loadDiv(5208, 1);
      clearStats();
      count_sig = 1'b1;
      stepCycle();
      applyStimulus(5208, 0, 2 * 5208);
      checkOutput("d5208_sample_n", n_sample, 2);
      checkOutput("d5208_tick_n", n_tick, 32);
      checkOutput("d5208_bad", n_bad, 0);
      count_sig = 1'b0;
      stepCycle();

      // Too-small divisor clamps to 32 (os_div 2), still acknowledged.
      loadDiv(10, 1);
      clearStats();
      count_sig = 1'b1;
      stepCycle();
      applyStimulus(32, 0, 320);
      checkOutput("clamp_done_at", done_at, 319);
      checkOutput("clamp_tick_n", n_tick, 160);
      checkOutput("clamp_bad", n_bad, 0);
      count_sig = 1'b0;
      stepCycle();

      // Load request while busy is rejected and the period stays 434.
      loadDiv(434, 1);
      clearStats();
      count_sig = 1'b1;
      stepCycle();
      applyStimulus(434, 0, 100);
      div_load = 1'b1;
      div_val  = DIV_W'(1000);
      applyStimulus(434, 100, 101);
      div_load = 1'b0;
      checkOutput("busy_load_err", int'(load_err), 1);
      checkOutput("busy_load_ack", int'(load_ack), 0);
      applyStimulus(434, 101, 4340);
      checkOutput("busy_load_done_at", done_at, 4339);
      checkOutput("busy_load_bad", n_bad, 0);
      checkOutput("err_pulse", int'(load_err), 0);
      count_sig = 1'b0;
      stepCycle();

      // Load and start on the same edge: the frame runs at the new divisor.
      clearStats();
      div_load  = 1'b1;
      div_val   = DIV_W'(100);
      count_sig = 1'b1;
      stepCycle();
      div_load = 1'b0;
      checkOutput("same_edge_ack", int'(load_ack), 1);
      applyStimulus(100, 0, 1000);
      checkOutput("same_edge_done_at", done_at, 999);
      checkOutput("same_edge_tick_n", n_tick, 160);
      checkOutput("same_edge_bad", n_bad, 0);
      count_sig = 1'b0;
      stepCycle();

      // Abort mid-bit 4.
      clearStats();
      count_sig = 1'b1;
      stepCycle();
      applyStimulus(100, 0, 450);
      count_sig = 1'b0;
      stepCycle();
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_idx", int'(bit_idx), 0);
      checkOutput("abort_done_n", n_done, 0);
      checkOutput("abort_bad", n_bad, 0);

      // Reset mid-frame restores the default divisor.
      loadDiv(200, 1);
      clearStats();
      count_sig = 1'b1;
      stepCycle();
      applyStimulus(200, 0, 300);
      rst_n = 1'b0; count_sig = 1'b0;
      stepCycle();
      checkOutput("midrst_busy", int'(busy), 0);
      checkOutput("midrst_idx", int'(bit_idx), 0);
      checkOutput("midrst_strobes", int'({sample_pulse, bit_end, frame_done, os_tick, load_ack, load_err}), 0);
      rst_n = 1'b1;
      stepCycle();
      clearStats();
      count_sig = 1'b1;
      stepCycle();
      applyStimulus(434, 0, 2 * 434);
      checkOutput("midrst_sample_n", n_sample, 2);
      checkOutput("midrst_bad", n_bad, 0);
      count_sig = 1'b0;
      stepCycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
